// File: rtl/alu_exec_unit_if.sv
// Upstream/downstream handshake bundle for the ALU execute stage.
// Operation side: in_valid/in_ready with funct and two operands.
// Result side: out_valid/out_ready with result, zero and illegal flags.
interface alu_exec_unit_if #(
  parameter int DATA_W = 32
);
  // Operation request from ALU_Control / register read
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        funct;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;

  // Result toward the writeback register
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              illegal;

  // Producer of operations and consumer of results
  modport master (
    output in_valid, funct, src1, src2, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  // The execute unit itself
  modport slave (
    input  in_valid, funct, src1, src2, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execute stage: addu/subu/and in one cycle, sll via 1-bit/cycle iterative shifter.
// Latency: 1 cycle for addu/subu/and/illegal/sll-by-0, shamt+1 cycles for sll.
// Backpressure: result held in DONE until out_ready; in_ready follows out_ready there.
module alu_exec_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  alu_exec_unit_if.slave bus
);

  localparam logic [5:0] FUNCT_ADDU = 6'h09;
  localparam logic [5:0] FUNCT_SUBU = 6'h0A;
  localparam logic [5:0] FUNCT_AND  = 6'h11;
  localparam logic [5:0] FUNCT_SLL  = 6'h21;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;
  logic                illegal_q, illegal_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;

  // Decoded view of the operation currently presented on the input side
  logic [DATA_W-1:0]   op_result;
  logic                op_illegal;
  logic                op_shift;
  logic [SHAMT_W-1:0]  op_shamt;

  logic                in_ready;
  logic                accept;
  logic                xfer;
  logic [DATA_W-1:0]   shifted;

  assign op_shamt = bus.src2[SHAMT_W-1:0];
  assign shifted  = {result_q[DATA_W-2:0], 1'b0};

  // Handshake qualifiers: a new op may enter from IDLE, or from DONE when the
  // held result leaves in the same cycle (keeps single-cycle ops bubble-free).
  assign xfer     = (state_q == ST_DONE) && bus.out_ready;
  assign in_ready = (state_q == ST_IDLE) || xfer;
  assign accept   = bus.in_valid && in_ready;

  // Decode funct into the first-cycle result and whether the shifter is needed
  always_comb begin
    op_result  = '0;
    op_illegal = 1'b0;
    op_shift   = 1'b0;
    unique case (bus.funct)
      FUNCT_ADDU: op_result = bus.src1 + bus.src2;
      FUNCT_SUBU: op_result = bus.src1 - bus.src2;
      FUNCT_AND:  op_result = bus.src1 & bus.src2;
      FUNCT_SLL: begin
        // Shifter starts from src1; a zero shamt is already the final answer
        op_result = bus.src1;
        op_shift  = (op_shamt != '0);
      end
      default: begin
        op_result  = '0;
        op_illegal = 1'b1;
      end
    endcase
  end

  // Next-state logic for the IDLE/SHIFT/DONE sequencer and its datapath
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // Result drained with nothing new arriving: fall back to IDLE
        if (xfer) begin
          state_d = ST_IDLE;
        end
        if (accept) begin
          result_d  = op_result;
          zero_d    = (op_result == '0);
          illegal_d = op_illegal;
          if (op_shift) begin
            cnt_d   = op_shamt;
            state_d = ST_SHIFT;
          end else begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end
        end
      end

      ST_SHIFT: begin
        // One bit per cycle; the last shift lands together with the DONE entry
        result_d = shifted;
        zero_d   = (shifted == '0);
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: table of directed ops plus
// hand-written sequences for back-to-back issue, back-pressure and reset abort.
module tb_alu_exec_unit;

  localparam int DATA_W = 32;
  localparam int NV     = 17;
  localparam int MAXLAT = 40;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.DATA_W(DATA_W)) bus ();

  alu_exec_unit #(.DATA_W(DATA_W), .SHAMT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_illegal;
    int          exp_lat;
  } vec_t;

  vec_t vecs [NV];

  int checks    = 0;
  int failures  = 0;
  int xfer_cnt  = 0;

  // Count every completed result transfer seen by the downstream side
  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.funct    = f;
    bus.src1     = a;
    bus.src2     = b;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, failures=%0d", failures);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int ready_low;
    int x0;
    bit seen;

    vecs[0]  = '{6'h09, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b0, 1};
    vecs[1]  = '{6'h0A, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1};
    vecs[2]  = '{6'h0A, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1};
    vecs[3]  = '{6'h11, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1};
    vecs[4]  = '{6'h00, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1, 1'b1, 1};
    vecs[5]  = '{6'h3F, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1};
    vecs[6]  = '{6'h08, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1};
    vecs[7]  = '{6'h21, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 1};
    vecs[8]  = '{6'h21, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 1};
    vecs[9]  = '{6'h21, 32'h0000_0001, 32'h0000_0005, 32'h0000_0020, 1'b0, 1'b0, 6};
    vecs[10] = '{6'h21, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 2};
    vecs[11] = '{6'h21, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, 32};
    vecs[12] = '{6'h21, 32'hFFFF_FFFF, 32'h0000_0004, 32'hFFFF_FFF0, 1'b0, 1'b0, 5};
    vecs[13] = '{6'h21, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 2};
    vecs[14] = '{6'h09, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1};
    vecs[15] = '{6'h11, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1};
    vecs[16] = '{6'h21, 32'h0000_0001, 32'hFFFF_FFE3, 32'h0000_0008, 1'b0, 1'b0, 4};

    // Reset state
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.funct     = 6'h00;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_result", bus.result, 32'h0);
    check_bit("rst_zero", bus.zero, 1'b0);
    check_bit("rst_illegal", bus.illegal, 1'b0);
    rst = 1'b0;
    #1;
    check_bit("rst_release_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    check_bit("idle_out_valid", bus.out_valid, 1'b0);
    check("idle_result", bus.result, 32'h0);

    // Table: each op issued alone, latency and in_ready-low cycles measured
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      check_bit($sformatf("vec%0d_pre_in_ready", i), bus.in_ready, 1'b1);
      bus.out_ready = 1'b1;
      drive_op(vecs[i].funct, vecs[i].src1, vecs[i].src2);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.funct    = 6'($urandom());
      bus.src1     = $urandom();
      bus.src2     = $urandom();
      lat       = 1;
      ready_low = 0;
      while (!bus.out_valid && lat < MAXLAT) begin
        if (!bus.in_ready) ready_low++;
        @(negedge clk);
        lat++;
      end
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_busy_cycles", i), ready_low, vecs[i].exp_lat - 1);
      check($sformatf("vec%0d_result", i), bus.result, vecs[i].exp_result);
      check_bit($sformatf("vec%0d_zero", i), bus.zero, vecs[i].exp_zero);
      check_bit($sformatf("vec%0d_illegal", i), bus.illegal, vecs[i].exp_illegal);
      @(negedge clk);
      check_bit($sformatf("vec%0d_drained", i), bus.out_valid, 1'b0);
    end

    // Back-to-back: subu then and accepted during the subu transfer cycle
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive_op(6'h0A, 32'h5, 32'h5);
    @(posedge clk);
    @(negedge clk);
    x0 = xfer_cnt;
    check_bit("b2b_subu_valid", bus.out_valid, 1'b1);
    check("b2b_subu_result", bus.result, 32'h0);
    check_bit("b2b_subu_zero", bus.zero, 1'b1);
    check_bit("b2b_in_ready_passthru", bus.in_ready, 1'b1);
    drive_op(6'h11, 32'h0000_F0F0, 32'h0000_FF00);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_bit("b2b_and_no_bubble", bus.out_valid, 1'b1);
    check("b2b_and_result", bus.result, 32'h0000_F000);
    check_bit("b2b_and_zero", bus.zero, 1'b0);
    @(negedge clk);
    check_bit("b2b_drained", bus.out_valid, 1'b0);
    check("b2b_xfers", xfer_cnt - x0, 2);

    // Back-pressure: result held 4 cycles, competing op ignored
    bus.out_ready = 1'b0;
    drive_op(6'h09, 32'h7, 32'h8);
    x0 = xfer_cnt;
    @(posedge clk);
    @(negedge clk);
    drive_op(6'h21, 32'hAAAA_AAAA, 32'h3);
    for (int k = 0; k < 4; k++) begin
      check_bit($sformatf("bp%0d_valid", k), bus.out_valid, 1'b1);
      check($sformatf("bp%0d_result", k), bus.result, 32'hF);
      check_bit($sformatf("bp%0d_in_ready", k), bus.in_ready, 1'b0);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_bit("bp_drained", bus.out_valid, 1'b0);
    @(negedge clk);
    check("bp_single_xfer", xfer_cnt - x0, 1);

    // Reset while a result is held in DONE
    bus.out_ready = 1'b0;
    drive_op(6'h09, 32'h1234, 32'h1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_bit("done_rst_pre_valid", bus.out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check_bit("done_rst_valid", bus.out_valid, 1'b0);
    check("done_rst_result", bus.result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // Abort: sll by 31 with reset pulsed 10 cycles after accept
    @(negedge clk);
    drive_op(6'h21, 32'h1, 32'h1F);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check_bit("abort_busy", bus.in_ready, 1'b0);
    rst = 1'b1;
    #1;
    check_bit("abort_valid", bus.out_valid, 1'b0);
    check("abort_result", bus.result, 32'h0);
    check_bit("abort_zero", bus.zero, 1'b0);
    check_bit("abort_illegal", bus.illegal, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_bit("abort_in_ready", bus.in_ready, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < MAXLAT; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check_bit("abort_no_out_valid", seen, 1'b0);

    // Clean restart after the abort
    drive_op(6'h09, 32'h1, 32'h1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_bit("restart_valid", bus.out_valid, 1'b1);
    check("restart_result", bus.result, 32'h2);
    check_bit("restart_illegal", bus.illegal, 1'b0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
